key_debounce: RTL and testbench

Debounces one active-low mechanical push-button and produces the stable key level `key_value` plus a single-cycle change strobe `key_flag`. It sits between the board key pin and the key consumers such as the beep toggle logic. Consumers detect a press as `key_flag && !key_value` and a release as `key_flag && key_value`. The block provides a 2-FF input synchronizer, a 4-state filter FSM and a saturating-free debounce counter.

---
 rtl/key_debounce.sv | 122 ++++++++++++
 tb/tb_key_debounce.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: cleans up one active-low push-button.
// The raw pin is synchronized through two flops. A four-state filter then
// requires DEBOUNCE_CNT consecutive stable samples before it accepts a new
// level. key_value is the accepted level. key_flag pulses for one cycle
// whenever key_value changes.
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CNT)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_value,
    output logic key_flag
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic            r_key_s1;
    logic            r_key_s2;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            r_key_value;
    logic            w_key_value_nxt;
    logic            r_key_flag;
    logic            w_key_flag_nxt;

    // Two-flop synchronizer. The idle level is 1 (released), so both flops reset to 1.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
        end
    end

    // Next-state logic for the filter FSM, the stable-time counter and the outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise a missed branch infers a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_key_value_nxt = r_key_value;
        w_key_flag_nxt  = 1'b0;
        unique case (r_state)
            RELEASED: begin
                if (!r_key_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (r_key_s2) begin
                    // Bounce: drop back without touching the outputs.
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = PRESSED;
                    w_cnt_nxt       = '0;
                    w_key_value_nxt = 1'b0;
                    w_key_flag_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (r_key_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!r_key_s2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = RELEASED;
                    w_cnt_nxt       = '0;
                    w_key_value_nxt = 1'b1;
                    w_key_flag_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, counter and registered outputs.
    // NOTE: reset clears every flop here at once, so a pending confirmation is dropped and no flag is emitted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= RELEASED;
            r_cnt       <= '0;
            r_key_value <= 1'b1;
            r_key_flag  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_value <= w_key_value_nxt;
            r_key_flag  <= w_key_flag_nxt;
        end
    end

    assign key_value = r_key_value;
    assign key_flag  = r_key_flag;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CNT = 4. Expected values are
// hand-derived: a level sampled at edge S0 is confirmed after edge S6.
module tb_key_debounce;

    localparam int N = 4;

    logic sys_clk;
    logic sys_rst_n;
    logic key;
    logic key_value;
    logic key_flag;

    int n_checks;
    int n_errors;
    int flag_cnt;
    logic prev_flag;
    logic double_flag;

    key_debounce #(.DEBOUNCE_CNT(N)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .key_value (key_value),
        .key_flag  (key_flag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count flag pulses and note any flag lasting two cycles, sampled mid-cycle.
    initial begin
        flag_cnt    = 0;
        prev_flag   = 1'b0;
        double_flag = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (key_flag === 1'b1) flag_cnt++;
            if (key_flag === 1'b1 && prev_flag === 1'b1) double_flag = 1'b1;
            prev_flag = key_flag;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int base;
        n_checks  = 0;
        n_errors  = 0;
        sys_rst_n = 1'b0;
        key       = 1'b1;

        // Reset state
        repeat (3) begin
            tick();
            check("reset_value", 32'(key_value), 32'd1);
            check("reset_flag", 32'(key_flag), 32'd0);
        end
        sys_rst_n = 1'b1;
        repeat (3) tick();
        check("idle_value", 32'(key_value), 32'd1);
        check("idle_flag", 32'(key_flag), 32'd0);

        // Clean press: key sampled 0 at S0, confirmed after S6
        key = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            tick();
            check($sformatf("press_value_S%0d", i), 32'(key_value), (i >= 6) ? 32'd0 : 32'd1);
            check($sformatf("press_flag_S%0d", i), 32'(key_flag), (i == 6) ? 32'd1 : 32'd0);
        end

        // Clean release
        key = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            tick();
            check($sformatf("release_value_S%0d", i), 32'(key_value), (i >= 6) ? 32'd1 : 32'd0);
            check($sformatf("release_flag_S%0d", i), 32'(key_flag), (i == 6) ? 32'd1 : 32'd0);
        end
        repeat (2) tick();
        check("two_flags_press_release", 32'(flag_cnt), 32'd2);

        // Bounce: low at S0..S2, high at S3, low from S4 -> confirm after S10
        for (int i = 0; i <= 11; i++) begin
            key = (i == 3) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("bounce_value_S%0d", i), 32'(key_value), (i >= 10) ? 32'd0 : 32'd1);
            check($sformatf("bounce_flag_S%0d", i), 32'(key_flag), (i == 10) ? 32'd1 : 32'd0);
        end
        check("bounce_single_flag", 32'(flag_cnt), 32'd3);

        key = 1'b1;
        repeat (10) tick();
        check("bounce_release_value", 32'(key_value), 32'd1);
        check("bounce_release_flags", 32'(flag_cnt), 32'd4);

        // Glitch: one sampled low cycle while released
        key = 1'b0;
        tick();
        key = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("glitch_value_%0d", i), 32'(key_value), 32'd1);
            check($sformatf("glitch_flag_%0d", i), 32'(key_flag), 32'd0);
        end
        check("glitch_cnt_zero", 32'(dut.r_cnt), 32'd0);
        check("glitch_no_flags", 32'(flag_cnt), 32'd4);

        // Reset mid-PRESS_WAIT: S2 enters wait (cnt 0), S4 leaves cnt at 2
        key = 1'b0;
        repeat (5) tick();
        check("midwait_cnt", 32'(dut.r_cnt), 32'd2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_value", 32'(key_value), 32'd1);
        check("async_reset_flag", 32'(key_flag), 32'd0);
        check("async_reset_cnt", 32'(dut.r_cnt), 32'd0);
        base = flag_cnt;
        // Key stays held low through reset
        repeat (4) begin
            tick();
            check("held_reset_value", 32'(key_value), 32'd1);
            check("held_reset_flag", 32'(key_flag), 32'd0);
        end
        check("reset_no_flag", 32'(flag_cnt), 32'(base));
        sys_rst_n = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            tick();
            check($sformatf("held_value_S%0d", i), 32'(key_value), (i >= 6) ? 32'd0 : 32'd1);
            check($sformatf("held_flag_S%0d", i), 32'(key_flag), (i == 6) ? 32'd1 : 32'd0);
        end
        tick();
        check("total_flags", 32'(flag_cnt), 32'd5);
        check("no_double_flag", 32'(double_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
